// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word memory responder with fixed response latency.
// Optional DMEM_ALIGN_CHECK_EN rejects accesses whose byte address is not word aligned.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_n;

    logic [3:0]    cnt;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH];
    logic          hs, enter, a_we, bad;
    logic [31:0]   a_addr, a_wdata;
    logic [3:0]    a_wstrb;
    logic [AW-1:0] idx;

    assign hs      = (state == IDLE) && req_valid;
    assign enter   = (state_n == RESP) && (state != RESP);
    // With LATENCY=1 the access happens on the handshake edge, before the capture registers are loaded.
    assign a_we    = (state == IDLE) ? req_we    : we_q;
    assign a_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign a_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign a_wstrb = (state == IDLE) ? req_wstrb : wstrb_q;
    assign idx     = a_addr[AW+1:2];
    assign bad     = (|a_addr[31:AW+2]) || (ALIGN_CHK && (|a_addr[1:0]));

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid && err_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req_valid ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
            WAIT:    state_n = (cnt <= 4'd1) ? RESP : WAIT;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (hs) begin
                cnt     <= 4'(LATENCY - 1);
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter) begin
                rdata_q <= (bad || a_we) ? 32'd0 : mem[idx];
                err_q   <= bad;
            end
        end
    end

    // Memory is never reset; a reset edge also cancels the pending write.
    always_ff @(posedge clk) begin
        if (!rst && enter && a_we && !bad)
            for (int i = 0; i < 4; i++)
                if (a_wstrb[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
    end
endmodule
